// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO port arbiters: FSM encoding and width helpers.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  // Ceiling log2 for constant width derivation; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Round-robin successor with explicit wrap for non-power-of-2 counts.
  function automatic int unsigned rr_next(input int unsigned i, input int unsigned n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first set request bit searching from ptr upward, mod N.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          any
);

  int j;

  // Walk offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    idx = '0;
    any = |req;
    j   = 0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % int'(N);
      if (req[IW'(j)]) idx = IW'(j);
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin write-port arbiter for the shared FIFO: bounded bursts per grant,
// back-pressured by the FIFO full flag.
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned DW    = 4,
  parameter int unsigned BURST = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NREQ-1:0]    req_i,
  input  logic [NREQ*DW-1:0] dat_i,
  input  logic               full_i,
  output logic [NREQ-1:0]    gnt_o,
  output logic [NREQ-1:0]    ack_o,
  output logic               wen_o,
  output logic [DW-1:0]      dat_o,
  output logic               busy_o
);

  localparam int unsigned IW = clog2(NREQ);
  localparam int unsigned BW = clog2(BURST + 1);

  arb_state_e      state;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   ptr;
  logic [BW-1:0]   bcnt;

  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic [DW-1:0]   slice [NREQ];
  logic            owner_req_c;
  logic            accept_c;
  logic            drop_c;

  rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .req (req_i),
    .ptr (ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  for (genvar k = 0; k < int'(NREQ); k++) begin : g_slice
    assign slice[k] = dat_i[k*DW +: DW];
  end

  // Write path is combinational from the registered owner so full_i gates it same-cycle.
  assign owner_req_c = req_i[owner];
  assign accept_c    = (state == OWN) && owner_req_c && !full_i;
  assign wen_o       = accept_c;
  assign ack_o       = NREQ'(accept_c) << owner;
  assign dat_o       = slice[owner];
  assign busy_o      = (state == OWN);

  // Release on the last word of a burst, or when the owner withdraws.
  assign drop_c = (accept_c && ((bcnt + BW'(1)) == BW'(BURST)))
                || ((state == OWN) && !owner_req_c);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      owner <= '0;
      ptr   <= '0;
      bcnt  <= '0;
      gnt_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            owner <= pick_idx;
            bcnt  <= '0;
            gnt_o <= NREQ'(1) << pick_idx;
            state <= OWN;
          end
        end
        OWN: begin
          if (drop_c) begin
            ptr   <= IW'(rr_next(32'(owner), NREQ));
            gnt_o <= '0;
            state <= IDLE;
          end else if (accept_c) begin
            bcnt <= bcnt + BW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb with NREQ=4, DW=4, BURST=2.
module tb_fifo_wr_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] dat;
  logic        full;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic        wen;
  logic [3:0]  dout;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;
  int nw    = 0;

  always #5 clk = ~clk;

  fifo_wr_arb #(.NREQ(4), .DW(4), .BURST(2)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .req_i  (req),
    .dat_i  (dat),
    .full_i (full),
    .gnt_o  (gnt),
    .ack_o  (ack),
    .wen_o  (wen),
    .dat_o  (dout),
    .busy_o (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [3:0] g, input logic [3:0] a,
                            input logic w, input logic b);
    check({tag, ".gnt"},  32'(gnt),  32'(g));
    check({tag, ".ack"},  32'(ack),  32'(a));
    check({tag, ".wen"},  32'(wen),  32'(w));
    check({tag, ".busy"}, 32'(busy), 32'(b));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  logic [3:0] oh;

  initial begin
    rst  = 1'b1;
    req  = 4'b0000;
    dat  = 16'h0000;
    full = 1'b0;
    tick();
    tick();

    // Reset state and quiet bus
    rst = 1'b0;
    settle();
    expect_out("rst", 4'b0000, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      expect_out("quiet", 4'b0000, 4'b0000, 1'b0, 1'b0);
    end

    // Single requester 2: two-word burst, gap, re-grant
    req = 4'b0100;
    dat = 16'h0A00;
    settle();
    expect_out("p2_idle", 4'b0000, 4'b0000, 1'b0, 1'b0);
    tick(); settle();
    expect_out("p2_w1", 4'b0100, 4'b0100, 1'b1, 1'b1);
    check("p2_w1.dat", 32'(dout), 32'hA);
    tick(); settle();
    expect_out("p2_w2", 4'b0100, 4'b0100, 1'b1, 1'b1);
    check("p2_w2.dat", 32'(dout), 32'hA);
    tick(); settle();
    expect_out("p2_gap", 4'b0000, 4'b0000, 1'b0, 1'b0);
    tick(); settle();
    expect_out("p2_regnt_w1", 4'b0100, 4'b0100, 1'b1, 1'b1);
    tick(); settle();
    expect_out("p2_regnt_w2", 4'b0100, 4'b0100, 1'b1, 1'b1);
    tick();
    req = 4'b0000;
    settle();
    expect_out("p2_end", 4'b0000, 4'b0000, 1'b0, 1'b0);
    tick();

    // All four requesting from ptr=0: order 0,1,2,3,0 with one gap cycle each
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b1111;
    dat = 16'h4321;
    settle();
    expect_out("p3_idle", 4'b0000, 4'b0000, 1'b0, 1'b0);
    for (int g = 0; g < 5; g++) begin
      oh = 4'b0001 << (g % 4);
      tick(); settle();
      expect_out($sformatf("p3_g%0d_w1", g), oh, oh, 1'b1, 1'b1);
      check($sformatf("p3_g%0d_w1.dat", g), 32'(dout), 32'((g % 4) + 1));
      tick(); settle();
      expect_out($sformatf("p3_g%0d_w2", g), oh, oh, 1'b1, 1'b1);
      check($sformatf("p3_g%0d_w2.dat", g), 32'(dout), 32'((g % 4) + 1));
      tick(); settle();
      expect_out($sformatf("p3_g%0d_gap", g), 4'b0000, 4'b0000, 1'b0, 1'b0);
    end
    req = 4'b0000;
    tick();

    // Requester 1 stalled by full for 5 cycles after its first write
    req = 4'b0010;
    dat = 16'h0050;
    settle();
    expect_out("p4_idle", 4'b0000, 4'b0000, 1'b0, 1'b0);
    tick(); settle();
    expect_out("p4_w1", 4'b0010, 4'b0010, 1'b1, 1'b1);
    check("p4_w1.dat", 32'(dout), 32'h5);
    nw += int'(wen);
    tick();
    full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle();
      expect_out($sformatf("p4_full%0d", i), 4'b0010, 4'b0000, 1'b0, 1'b1);
      nw += int'(wen);
      tick();
    end
    full = 1'b0;
    settle();
    expect_out("p4_w2", 4'b0010, 4'b0010, 1'b1, 1'b1);
    check("p4_w2.dat", 32'(dout), 32'h5);
    nw += int'(wen);
    tick();
    req = 4'b0000;
    settle();
    expect_out("p4_rel", 4'b0000, 4'b0000, 1'b0, 1'b0);
    nw += int'(wen);
    check("p4_writes", 32'(nw), 32'd2);
    tick();

    // Requester 3 withdraws after one ack; grant wraps to 0
    req = 4'b1000;
    dat = 16'h7000;
    settle();
    expect_out("p5_idle", 4'b0000, 4'b0000, 1'b0, 1'b0);
    tick(); settle();
    expect_out("p5_w1", 4'b1000, 4'b1000, 1'b1, 1'b1);
    check("p5_w1.dat", 32'(dout), 32'h7);
    tick();
    req = 4'b0001;
    dat = 16'h0009;
    settle();
    expect_out("p5_drop", 4'b1000, 4'b0000, 1'b0, 1'b1);
    tick(); settle();
    expect_out("p5_gap", 4'b0000, 4'b0000, 1'b0, 1'b0);
    tick(); settle();
    expect_out("p5_wrap_w1", 4'b0001, 4'b0001, 1'b1, 1'b1);
    check("p5_wrap_w1.dat", 32'(dout), 32'h9);
    tick(); settle();
    expect_out("p5_wrap_w2", 4'b0001, 4'b0001, 1'b1, 1'b1);
    tick();
    req = 4'b0000;
    settle();
    expect_out("p5_end", 4'b0000, 4'b0000, 1'b0, 1'b0);
    tick();

    // Reset mid-burst: everything clears, next grant restarts at requester 0
    req = 4'b1111;
    dat = 16'h4321;
    settle();
    expect_out("p6_idle", 4'b0000, 4'b0000, 1'b0, 1'b0);
    tick(); settle();
    expect_out("p6_w1", 4'b0010, 4'b0010, 1'b1, 1'b1);
    check("p6_w1.dat", 32'(dout), 32'h2);
    tick();
    rst = 1'b1;
    settle();
    check("p6_pre_rst.gnt", 32'(gnt), 32'b0010);
    tick();
    rst = 1'b0;
    settle();
    expect_out("p6_after_rst", 4'b0000, 4'b0000, 1'b0, 1'b0);
    tick(); settle();
    expect_out("p6_regnt", 4'b0001, 4'b0001, 1'b1, 1'b1);
    check("p6_regnt.dat", 32'(dout), 32'h1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
